conv_mac_pipe: RTL and testbench

//  Pipelined, multi-channel kernel multiply-accumulate for the conv datapath. Takes one

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/mac_window_sum.sv | 40 ++++
 rtl/conv_mac_pipe.sv | 106 ++++++++++
 tb/tb_conv_mac_pipe.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared helpers for the conv MAC datapath: accumulator sizing and output
// post-processing (ReLU, saturation) on a wide signed working type.
package conv_pkg;

    localparam int WideWidth = 64;

    typedef logic signed [WideWidth-1:0] wide_t;

    // Wide enough that KernelArea*InChannels products plus one bias cannot overflow.
    function automatic int acc_width(input int kernel_area, input int width_in,
                                     input int weight_width, input int bias_width,
                                     input int in_channels);
        int prod_w;
        int base_w;
        prod_w = weight_width + width_in + 1;
        base_w = (prod_w > bias_width) ? prod_w : bias_width;
        return base_w + $clog2(kernel_area * in_channels + 1) + 1;
    endfunction

    function automatic wide_t relu(input wide_t v);
        return (v < 0) ? '0 : v;
    endfunction

    function automatic wide_t saturate(input wide_t v, input int width);
        wide_t hi;
        wide_t lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t post(input wide_t v, input int width,
                                   input bit relu_en, input bit sat_en);
        wide_t r;
        r = relu_en ? relu(v) : v;
        return sat_en ? saturate(r, width) : r;
    endfunction

endpackage

// File: rtl/mac_window_sum.sv
// Combinational dot product of one kernel window against its weights.
// A 2-bit pixel width means binary pixels: the weight is added when the pixel is non-zero.
module mac_window_sum #(
    parameter int KernelWidth = 3,
    parameter int WidthIn     = 2,
    parameter int WeightWidth = 2,
    parameter int AccWidth    = 24
) (
    input  logic [KernelWidth*KernelWidth*WidthIn-1:0]     window,
    input  logic [KernelWidth*KernelWidth*WeightWidth-1:0] weights,
    output logic signed [AccWidth-1:0]                     sum
);

    localparam int KernelArea = KernelWidth * KernelWidth;

    logic [WidthIn-1:0]            pix;
    logic [WeightWidth-1:0]        wt;
    logic signed [AccWidth-1:0]    wt_ext;
    logic signed [AccWidth-1:0]    pix_ext;

    always_comb begin
        sum     = '0;
        pix     = '0;
        wt      = '0;
        wt_ext  = '0;
        pix_ext = '0;
        for (int i = 0; i < KernelArea; i++) begin
            pix     = window[i*WidthIn +: WidthIn];
            wt      = weights[i*WeightWidth +: WeightWidth];
            wt_ext  = {{(AccWidth-WeightWidth){wt[WeightWidth-1]}}, wt};
            pix_ext = {{(AccWidth-WidthIn){1'b0}}, pix};
            if (WidthIn == 2) begin
                if (pix != '0) sum = sum + wt_ext;
            end else begin
                sum = sum + wt_ext * pix_ext;
            end
        end
    end

endmodule

// File: rtl/conv_mac_pipe.sv
// Two-stage multi-channel kernel MAC: window dot product + bias into stage 1,
// channel accumulation and ReLU/saturation into the output register.
module conv_mac_pipe
    import conv_pkg::*;
#(
    parameter int KernelWidth = 3,
    parameter int WidthIn     = 2,
    parameter int WeightWidth = 2,
    parameter int WidthOut    = 16,
    parameter int InChannels  = 1,
    parameter int BiasWidth   = 16,
    parameter int ReluEn      = 0,
    parameter int SaturateEn  = 1
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            valid_i,
    output logic                                            ready_o,
    input  logic [KernelWidth*KernelWidth*WidthIn-1:0]      window_i,
    input  logic [KernelWidth*KernelWidth*WeightWidth-1:0]  weights_i,
    input  logic [BiasWidth-1:0]                            bias_i,
    output logic                                            valid_o,
    input  logic                                            ready_i,
    output logic [WidthOut-1:0]                             data_o,
    output logic                                            last_o
);

    localparam int KernelArea = KernelWidth * KernelWidth;
    localparam int AccWidth   = acc_width(KernelArea, WidthIn, WeightWidth, BiasWidth, InChannels);
    localparam int ChWidth    = (InChannels > 1) ? $clog2(InChannels) : 1;
    localparam logic [ChWidth-1:0] LastCh = ChWidth'(InChannels - 1);

    logic                       stall;
    logic                       accept;
    logic [ChWidth-1:0]         ch;
    logic signed [AccWidth-1:0] window_sum;
    logic signed [AccWidth-1:0] bias_ext;
    logic signed [AccWidth-1:0] partial;
    logic signed [AccWidth-1:0] total;
    wide_t                      total_wide;

    logic                       s1_valid;
    logic                       s1_first;
    logic                       s1_last;
    logic signed [AccWidth-1:0] s1_partial;
    logic signed [AccWidth-1:0] acc;

    mac_window_sum #(
        .KernelWidth (KernelWidth),
        .WidthIn     (WidthIn),
        .WeightWidth (WeightWidth),
        .AccWidth    (AccWidth)
    ) u_window_sum (
        .window  (window_i),
        .weights (weights_i),
        .sum     (window_sum)
    );

    // Any unconsumed result freezes the whole pipe, so nothing in flight is ever dropped.
    assign ready_o = !(valid_o && !ready_i);
    assign stall   = !ready_o;
    assign accept  = valid_i && ready_o;
    assign last_o  = 1'b1;

    assign bias_ext   = {{(AccWidth-BiasWidth){bias_i[BiasWidth-1]}}, bias_i};
    assign partial    = window_sum + ((ch == '0) ? bias_ext : '0);
    assign total      = (s1_first ? '0 : acc) + s1_partial;
    assign total_wide = {{(WideWidth-AccWidth){total[AccWidth-1]}}, total};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ch <= '0;
        end else if (accept) begin
            ch <= (ch == LastCh) ? '0 : ch + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_partial <= '0;
            acc        <= '0;
            valid_o    <= 1'b0;
            data_o     <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_partial <= partial;
                s1_first   <= (ch == '0);
                s1_last    <= (ch == LastCh);
            end
            valid_o <= s1_valid && s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    data_o <= WidthOut'(post(total_wide, WidthOut, ReluEn != 0, SaturateEn != 0));
                    acc    <= '0;
                end else begin
                    acc <= total;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Scoreboard bench for conv_mac_pipe across five parameterisations
// (binary 2-channel, binary ReLU on/off, 8-bit saturate/wrap).
module tb_conv_mac_pipe;

    typedef struct {
        int idx;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   asserts = 0;
    int   fails = 0;

    logic        vin[5];
    logic        rdy_in[5];
    logic        rdy_out[5];
    logic        vout[5];
    logic        lout[5];
    logic [17:0] win2[3];
    logic [71:0] win8[2];
    logic [17:0] wt[5];
    logic [15:0] bias[5];
    logic [15:0] dout16[3];
    logic [7:0]  dout8[2];

    exp_t exp_q[$];
    int   n_out[5];
    int   first_cyc[5];
    int   last_cyc[5];
    int   last_acc;

    localparam logic [17:0] OnesPix = {9{2'b01}};
    localparam logic [17:0] WtPlus  = {9{2'b01}};
    localparam logic [17:0] WtMinus = {9{2'b11}};
    localparam logic [71:0] FullPix = {9{8'hFF}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv_mac_pipe #(.KernelWidth(3), .WidthIn(2), .WeightWidth(2), .WidthOut(16), .InChannels(2),
                    .BiasWidth(16), .ReluEn(0), .SaturateEn(1)) u_a (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[0]), .ready_o(rdy_out[0]), .window_i(win2[0]),
        .weights_i(wt[0]), .bias_i(bias[0]), .valid_o(vout[0]), .ready_i(rdy_in[0]),
        .data_o(dout16[0]), .last_o(lout[0]));

    conv_mac_pipe #(.KernelWidth(3), .WidthIn(2), .WeightWidth(2), .WidthOut(16), .InChannels(1),
                    .BiasWidth(16), .ReluEn(1), .SaturateEn(1)) u_b (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[1]), .ready_o(rdy_out[1]), .window_i(win2[1]),
        .weights_i(wt[1]), .bias_i(bias[1]), .valid_o(vout[1]), .ready_i(rdy_in[1]),
        .data_o(dout16[1]), .last_o(lout[1]));

    conv_mac_pipe #(.KernelWidth(3), .WidthIn(2), .WeightWidth(2), .WidthOut(16), .InChannels(1),
                    .BiasWidth(16), .ReluEn(0), .SaturateEn(1)) u_c (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[2]), .ready_o(rdy_out[2]), .window_i(win2[2]),
        .weights_i(wt[2]), .bias_i(bias[2]), .valid_o(vout[2]), .ready_i(rdy_in[2]),
        .data_o(dout16[2]), .last_o(lout[2]));

    conv_mac_pipe #(.KernelWidth(3), .WidthIn(8), .WeightWidth(2), .WidthOut(8), .InChannels(1),
                    .BiasWidth(16), .ReluEn(0), .SaturateEn(1)) u_d (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[3]), .ready_o(rdy_out[3]), .window_i(win8[0]),
        .weights_i(wt[3]), .bias_i(bias[3]), .valid_o(vout[3]), .ready_i(rdy_in[3]),
        .data_o(dout8[0]), .last_o(lout[3]));

    conv_mac_pipe #(.KernelWidth(3), .WidthIn(8), .WeightWidth(2), .WidthOut(8), .InChannels(1),
                    .BiasWidth(16), .ReluEn(0), .SaturateEn(0)) u_e (
        .clk_i(clk), .rst_i(rst), .valid_i(vin[4]), .ready_o(rdy_out[4]), .window_i(win8[1]),
        .weights_i(wt[4]), .bias_i(bias[4]), .valid_o(vout[4]), .ready_i(rdy_in[4]),
        .data_o(dout8[1]), .last_o(lout[4]));

    // Binary-mode reference: add the signed weight wherever the pixel is non-zero.
    function automatic int model_bin(input logic [17:0] w, input logic [17:0] k);
        int s;
        logic [1:0] p;
        logic signed [1:0] q;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            p = w[i*2 +: 2];
            q = k[i*2 +: 2];
            if (p != 2'b00) s += int'(q);
        end
        return s;
    endfunction

    task automatic push_exp(input int idx, input int val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Monitor: every transferred result is popped against the scoreboard.
    int   mon_got;
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                if (vout[i] && rdy_in[i]) begin
                    if (i < 3) mon_got = int'($signed(dout16[i]));
                    else       mon_got = int'($signed(dout8[i-3]));
                    n_out[i]++;
                    if (n_out[i] == 1) first_cyc[i] = cyc;
                    last_cyc[i] = cyc;
                    asserts++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_output inst=%0d got=%0d expected none", i, mon_got);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.idx != i || mon_e.val != mon_got) begin
                            fails++;
                            $display("FAIL result inst=%0d got=%0d expected inst=%0d val=%0d",
                                     i, mon_got, mon_e.idx, mon_e.val);
                        end
                    end
                    asserts++;
                    if (lout[i] !== 1'b1) begin
                        fails++;
                        $display("FAIL last_o inst=%0d got=%b expected 1", i, lout[i]);
                    end
                end
            end
        end
    end

    task automatic send_beat(input int idx, input logic [71:0] w, input logic [17:0] k,
                             input logic [15:0] b);
        int budget;
        if (idx < 3) win2[idx] = w[17:0];
        else         win8[idx-3] = w;
        wt[idx]   = k;
        bias[idx] = b;
        vin[idx]  = 1'b1;
        budget = 0;
        @(negedge clk);
        while (!rdy_out[idx] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            asserts++;
            fails++;
            $display("FAIL accept_timeout inst=%0d got ready_o=0 expected 1", idx);
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        vin[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        asserts++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 5; i++) begin
            n_out[i]     = 0;
            first_cyc[i] = -1;
            last_cyc[i]  = -1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            asserts++;
            if (vout[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_valid inst=%0d got=%b expected 0", i, vout[i]);
            end
            asserts++;
            if (rdy_out[i] !== 1'b1) begin
                fails++;
                $display("FAIL reset_ready inst=%0d got=%b expected 1", i, rdy_out[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (dout16[i] !== 16'h0) begin
                fails++;
                $display("FAIL reset_data inst=%0d got=%h expected 0", i, dout16[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Two all-ones beats into the 2-channel instance; the second beat's bias must be ignored.
    task automatic test_two_channel();
        int acc_cyc;
        clear_counts();
        push_exp(0, 18);
        send_beat(0, 72'(OnesPix), WtPlus, 16'd0);
        send_beat(0, 72'(OnesPix), WtPlus, 16'd55);
        acc_cyc = last_acc;
        @(negedge clk);
        asserts++;
        if (vout[0] !== 1'b0) begin
            fails++;
            $display("FAIL early_valid got=%b expected 0", vout[0]);
        end
        wait_drain();
        asserts++;
        if (first_cyc[0] != acc_cyc + 1) begin
            fails++;
            $display("FAIL latency got_cyc=%0d expected_cyc=%0d", first_cyc[0], acc_cyc + 1);
        end
        asserts++;
        if (n_out[0] != 1) begin
            fails++;
            $display("FAIL two_channel_count got=%0d expected 1", n_out[0]);
        end
    endtask

    task automatic test_relu();
        push_exp(1, 0);
        send_beat(1, 72'(OnesPix), WtMinus, 16'd3);
        wait_drain();
        push_exp(2, -6);
        send_beat(2, 72'(OnesPix), WtMinus, 16'd3);
        wait_drain();
    endtask

    task automatic test_saturate();
        push_exp(3, 127);
        send_beat(3, FullPix, WtPlus, 16'd0);
        wait_drain();
        push_exp(4, -9);
        send_beat(4, FullPix, WtPlus, 16'd0);
        wait_drain();
    endtask

    task automatic test_backpressure();
        logic [17:0] w[8];
        logic [17:0] k[8];
        logic [15:0] b[8];
        logic [15:0] hold;
        int budget;
        clear_counts();
        for (int i = 0; i < 8; i++) begin
            w[i] = 18'($urandom);
            k[i] = 18'($urandom);
            b[i] = 16'($urandom_range(0, 40));
        end
        for (int i = 0; i < 8; i += 2)
            push_exp(0, model_bin(w[i], k[i]) + int'($signed(b[i])) + model_bin(w[i+1], k[i+1]));
        rdy_in[0] = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_beat(0, 72'(w[i]), k[i], b[i]);
            end
            begin
                budget = 0;
                @(negedge clk);
                while (!vout[0] && budget < 50) begin
                    @(negedge clk);
                    budget++;
                end
                hold = dout16[0];
                repeat (5) begin
                    @(negedge clk);
                    asserts++;
                    if (vout[0] !== 1'b1) begin
                        fails++;
                        $display("FAIL stall_valid got=%b expected 1", vout[0]);
                    end
                    asserts++;
                    if (rdy_out[0] !== 1'b0) begin
                        fails++;
                        $display("FAIL stall_ready got=%b expected 0", rdy_out[0]);
                    end
                    asserts++;
                    if (dout16[0] !== hold) begin
                        fails++;
                        $display("FAIL stall_hold got=%h expected %h", dout16[0], hold);
                    end
                end
                @(posedge clk);
                #1;
                rdy_in[0] = 1'b1;
            end
        join
        wait_drain();
        asserts++;
        if (n_out[0] != 4) begin
            fails++;
            $display("FAIL stall_count got=%0d expected 4", n_out[0]);
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        send_beat(0, 72'(OnesPix), WtPlus, 16'd7);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        asserts++;
        if (vout[0] !== 1'b0 || n_out[0] != 0) begin
            fails++;
            $display("FAIL reset_mid_output got valid=%b count=%0d expected 0", vout[0], n_out[0]);
        end
        push_exp(0, 18);
        send_beat(0, 72'(OnesPix), WtPlus, 16'd0);
        send_beat(0, 72'(OnesPix), WtPlus, 16'd0);
        wait_drain();
        asserts++;
        if (n_out[0] != 1) begin
            fails++;
            $display("FAIL reset_mid_count got=%0d expected 1", n_out[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] w;
        logic [17:0] k;
        int bv;
        int first_acc;
        clear_counts();
        first_acc = 0;
        for (int i = 0; i < 8; i++) begin
            w  = 18'($urandom);
            k  = 18'($urandom);
            bv = int'($urandom_range(0, 200)) - 100;
            push_exp(2, model_bin(w, k) + bv);
            send_beat(2, 72'(w), k, 16'(bv));
            if (i == 0) first_acc = last_acc;
        end
        wait_drain();
        asserts++;
        if (n_out[2] != 8) begin
            fails++;
            $display("FAIL b2b_count got=%0d expected 8", n_out[2]);
        end
        asserts++;
        if (first_cyc[2] != first_acc + 1) begin
            fails++;
            $display("FAIL b2b_latency got_cyc=%0d expected_cyc=%0d", first_cyc[2], first_acc + 1);
        end
        asserts++;
        if (last_cyc[2] - first_cyc[2] != 7) begin
            fails++;
            $display("FAIL b2b_spacing got=%0d expected 7", last_cyc[2] - first_cyc[2]);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vin[i]    = 1'b0;
            rdy_in[i] = 1'b1;
            wt[i]     = '0;
            bias[i]   = '0;
        end
        for (int i = 0; i < 3; i++) win2[i] = '0;
        for (int i = 0; i < 2; i++) win8[i] = '0;
        clear_counts();
        test_reset();
        test_two_channel();
        test_relu();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
